// File: rtl/phase_detect_filter.sv
// -----------------------------------------------------------------------------
// phase_detect_filter
//
// Digital phase/frequency detector plus PI loop filter for the ADPLL. Sits
// directly upstream of the phase-accumulator DCO: rising edges of the external
// reference are compared with rising edges of the DCO output. Their separation
// is measured in fpga_clk_i cycles and turned into the K tuning word that
// drives the accumulator's k_val_i.
//
// Ports
//   fpga_clk_i  in   1        system clock, all logic on the rising edge
//   reset_i     in   1        synchronous, active-low reset
//   enable_i    in   1        loop enable; low freezes the loop
//   ref_clk_i   in   1        reference clock (asynchronous)
//   dco_clk_i   in   1        DCO output clock (asynchronous)
//   k_val_o     out  K_WIDTH  tuning word, unsigned, registered, never 0
//   k_valid_o   out  1        one-cycle pulse when k_val_o takes a new value
//   lock_o      out  1        lock indicator
//
// Optional feature
//   PHASE_DETECT_LOCK_DET_EN  when defined, a lock counter counts consecutive
//                             updates with |err| <= LOCK_TOL. lock_o is high
//                             while the count sits at LOCK_COUNT. When it is
//                             not defined, lock_o is tied low.
//
// Measurement flow
//   IDLE waits for the first edge of either clock. REF_FIRST / DCO_FIRST count
//   cycles until the other clock's edge closes the measurement. A second edge
//   of the leading clock is a cycle slip and reports full-scale error. UPDATE
//   runs the PI filter for one cycle and then returns to IDLE.
//   Closing edge pulse in cycle N -> UPDATE in N+1 -> k_val_o/k_valid_o in N+2.
// -----------------------------------------------------------------------------
module phase_detect_filter #(
  parameter int K_WIDTH    = 9,
  parameter int ERR_WIDTH  = 10,
  parameter int KP_SHIFT   = 2,
  parameter int KI_SHIFT   = 5,
  parameter int K_INIT     = 64,
  parameter int LOCK_TOL   = 2,
  parameter int LOCK_COUNT = 16
) (
  input  logic               fpga_clk_i,
  input  logic               reset_i,
  input  logic               enable_i,
  input  logic               ref_clk_i,
  input  logic               dco_clk_i,
  output logic [K_WIDTH-1:0] k_val_o,
  output logic               k_valid_o,
  output logic               lock_o
);

  // The integrator carries one bit more than the K path plus the integral shift.
  // Because of that margin, integ >>> KI_SHIFT can swing across the full K range.
  localparam int INT_WIDTH = K_WIDTH + KI_SHIFT + 1;
  localparam int INT_EXT   = INT_WIDTH + 1;
  localparam int CNT_WIDTH = ERR_WIDTH - 1;
  localparam int SUM_WIDTH = INT_WIDTH + 2;

  localparam logic [CNT_WIDTH-1:0]        CNT_MAX     = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0]        CNT_ONE     = CNT_WIDTH'(1);
  localparam logic signed [ERR_WIDTH-1:0] ERR_POS_MAX = {1'b0, {CNT_WIDTH{1'b1}}};
  localparam logic signed [ERR_WIDTH-1:0] ERR_NEG_MAX = -ERR_POS_MAX;
  localparam logic signed [INT_WIDTH-1:0] INT_MAX     = {1'b0, {(INT_WIDTH-1){1'b1}}};
  localparam logic signed [INT_WIDTH-1:0] INT_MIN     = {1'b1, {(INT_WIDTH-1){1'b0}}};
  localparam logic signed [SUM_WIDTH-1:0] K_LO        = SUM_WIDTH'(1);
  localparam logic signed [SUM_WIDTH-1:0] K_HI        = SUM_WIDTH'((1 << K_WIDTH) - 1);
  localparam logic signed [SUM_WIDTH-1:0] K_BASE      = SUM_WIDTH'(K_INIT);
  localparam logic [K_WIDTH-1:0]          K_RESET     = K_WIDTH'(K_INIT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REF_FIRST = 2'd1,
    DCO_FIRST = 2'd2,
    UPDATE    = 2'd3
  } state_t;

  // Saturate a one-bit-wider integrator sum back into INT_WIDTH.
  // Overflow shows up as a disagreement between the two top bits.
  function automatic logic signed [INT_WIDTH-1:0] sat_integ(
    input logic signed [INT_EXT-1:0] v
  );
    if (v[INT_EXT-1] != v[INT_EXT-2]) begin
      return v[INT_EXT-1] ? INT_MIN : INT_MAX;
    end
    return $signed(v[INT_WIDTH-1:0]);
  endfunction

  // Clamp the PI output into [1, 2^K_WIDTH-1]. A zero tuning word would stall
  // the DCO, and the loop could then never recover.
  function automatic logic [K_WIDTH-1:0] clamp_k(
    input logic signed [SUM_WIDTH-1:0] v
  );
    if (v < K_LO) begin
      return K_WIDTH'(1);
    end
    if (v > K_HI) begin
      return {K_WIDTH{1'b1}};
    end
    return v[K_WIDTH-1:0];
  endfunction

  logic ref_p0, ref_p1, ref_p2;
  logic dco_p0, dco_p1, dco_p2;
  logic ref_rise, dco_rise;

  state_t                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d, cnt_inc;
  logic signed [ERR_WIDTH-1:0] err_d, err_p3;

  logic                        vld_p3;
  logic signed [INT_EXT-1:0]   integ_sum_p3;
  logic signed [INT_WIDTH-1:0] integ_new_p3;
  logic signed [SUM_WIDTH-1:0] k_sum_p3;
  logic signed [INT_WIDTH-1:0] integ_q;
  logic [K_WIDTH-1:0]          k_val_p4;
  logic                        vld_p4;

  // ---- Stage p0..p2: two-flop synchronisers plus edge registers -------------
  // Both clocks go through identical paths so that the measured separation is
  // not biased by the input stage.
  always_ff @(posedge fpga_clk_i) begin
    if (!reset_i) begin
      ref_p0 <= 1'b0;
      ref_p1 <= 1'b0;
      ref_p2 <= 1'b0;
      dco_p0 <= 1'b0;
      dco_p1 <= 1'b0;
      dco_p2 <= 1'b0;
    end else begin
      ref_p0 <= ref_clk_i;
      ref_p1 <= ref_p0;
      ref_p2 <= ref_p1;
      dco_p0 <= dco_clk_i;
      dco_p1 <= dco_p0;
      dco_p2 <= dco_p1;
    end
  end

  assign ref_rise = ref_p1 & ~ref_p2;
  assign dco_rise = dco_p1 & ~dco_p2;

  // ---- Stage p3: edge-order FSM and separation counter ----------------------
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_p3;
    if (!enable_i) begin
      // Abandon any pending measurement. Re-enabling starts from a clean IDLE.
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (ref_rise && dco_rise) begin
            err_d   = '0;
            state_d = UPDATE;
          end else if (ref_rise) begin
            cnt_d   = CNT_ONE;
            state_d = REF_FIRST;
          end else if (dco_rise) begin
            cnt_d   = CNT_ONE;
            state_d = DCO_FIRST;
          end
        end
        REF_FIRST: begin
          // A DCO edge closes the measurement, even when it coincides with
          // the next reference edge.
          if (dco_rise) begin
            err_d   = $signed({1'b0, cnt_q});
            state_d = UPDATE;
          end else if (ref_rise) begin
            err_d   = ERR_POS_MAX;
            state_d = UPDATE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        DCO_FIRST: begin
          if (ref_rise) begin
            err_d   = -$signed({1'b0, cnt_q});
            state_d = UPDATE;
          end else if (dco_rise) begin
            err_d   = ERR_NEG_MAX;
            state_d = UPDATE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          // UPDATE: edges seen in this cycle are deliberately dropped.
          cnt_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge fpga_clk_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge fpga_clk_i) begin
    err_p3 <= err_d;
  end

  // ---- Stage p4: PI filter, registered tuning word --------------------------
  assign vld_p3       = enable_i && (state_q == UPDATE);
  assign integ_sum_p3 = INT_EXT'(integ_q) + INT_EXT'(err_p3);
  assign integ_new_p3 = sat_integ(integ_sum_p3);
  assign k_sum_p3     = K_BASE
                      + SUM_WIDTH'(err_p3 >>> KP_SHIFT)
                      + SUM_WIDTH'(integ_new_p3 >>> KI_SHIFT);

  always_ff @(posedge fpga_clk_i) begin
    if (!reset_i) begin
      integ_q  <= '0;
      k_val_p4 <= K_RESET;
      vld_p4   <= 1'b0;
    end else begin
      vld_p4 <= vld_p3;
      if (vld_p3) begin
        integ_q  <= integ_new_p3;
        k_val_p4 <= clamp_k(k_sum_p3);
      end
    end
  end

  assign k_val_o   = k_val_p4;
  assign k_valid_o = vld_p4;

`ifdef PHASE_DETECT_LOCK_DET_EN
  localparam int LCNT_WIDTH = $clog2(LOCK_COUNT + 1);
  localparam logic [LCNT_WIDTH-1:0] LCNT_FULL = LCNT_WIDTH'(LOCK_COUNT);
  localparam logic [LCNT_WIDTH-1:0] LCNT_ONE  = LCNT_WIDTH'(1);
  localparam logic [ERR_WIDTH-1:0]  LOCK_TOL_U = ERR_WIDTH'(LOCK_TOL);

  logic [ERR_WIDTH-1:0]  err_abs_p3;
  logic [LCNT_WIDTH-1:0] lock_cnt_q, lock_cnt_d;
  logic                  lock_q;

  // |err| fits in ERR_WIDTH bits because err never reaches the negative rail.
  assign err_abs_p3 = err_p3[ERR_WIDTH-1] ? $unsigned(-err_p3) : $unsigned(err_p3);

  always_comb begin
    lock_cnt_d = '0;
    if (err_abs_p3 <= LOCK_TOL_U) begin
      lock_cnt_d = (lock_cnt_q == LCNT_FULL) ? lock_cnt_q : lock_cnt_q + LCNT_ONE;
    end
  end

  // Lock state advances only on filter updates, so it moves with k_valid_o.
  always_ff @(posedge fpga_clk_i) begin
    if (!reset_i) begin
      lock_cnt_q <= '0;
      lock_q     <= 1'b0;
    end else if (vld_p3) begin
      lock_cnt_q <= lock_cnt_d;
      lock_q     <= (lock_cnt_d == LCNT_FULL);
    end
  end

  assign lock_o = lock_q;
`else
  assign lock_o = 1'b0;
`endif

endmodule

// File: tb/tb_phase_detect_filter.sv
// Bench for phase_detect_filter. Edges are scheduled by cycle index. The
// reference model derives the phase error from the scheduled separation and
// then applies the PI/lock arithmetic with plain integer math.
module tb_phase_detect_filter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       ref_clk;
  logic       dco_clk;
  logic [8:0] k_val;
  logic       k_valid;
  logic       lock;

  int vectors     = 0;
  int miscompares = 0;

  int integ_m;
  int k_m;
  int lcnt_m;
  bit lock_m;

`ifdef PHASE_DETECT_LOCK_DET_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  phase_detect_filter dut (
    .fpga_clk_i (clk),
    .reset_i    (reset_n),
    .enable_i   (enable),
    .ref_clk_i  (ref_clk),
    .dco_clk_i  (dco_clk),
    .k_val_o    (k_val),
    .k_valid_o  (k_valid),
    .lock_o     (lock)
  );

  function automatic int floor_div(input int a, input int b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  task automatic model_reset();
    integ_m = 0;
    k_m     = 64;
    lcnt_m  = 0;
    lock_m  = 1'b0;
  endtask

  task automatic model_update(input int err);
    int k;
    integ_m = integ_m + err;
    if (integ_m > 16383)  integ_m = 16383;
    if (integ_m < -16384) integ_m = -16384;
    k = 64 + floor_div(err, 4) + floor_div(integ_m, 32);
    if (k < 1)   k = 1;
    if (k > 511) k = 511;
    k_m = k;
    if (err >= -2 && err <= 2) begin
      if (lcnt_m < 16) lcnt_m++;
    end else begin
      lcnt_m = 0;
    end
    lock_m = LOCK_EN && (lcnt_m == 16);
  endtask

  // Runs len cycles. Each scheduled edge (-1 = none) holds its input high for
  // 2 cycles, and enable is low for cycle indices in [en_off, en_on). The task
  // reports the number of k_valid pulses, the index of the first one, and k/lock
  // at the last pulse (or at the end when there was no pulse). It also reports
  // whether k_val was ever seen at 0.
  task automatic run_pat(input int rt0, input int rt1, input int dt0, input int dt1,
                         input int en_off, input int en_on, input int len,
                         output int np, output int at, output logic [8:0] kv,
                         output logic lk, output bit zero);
    np = 0; at = -1; zero = 1'b0; kv = k_val; lk = lock;
    for (int j = 0; j < len; j++) begin
      if (k_valid === 1'b1) begin
        np++;
        if (at < 0) at = j;
        kv = k_val;
        lk = lock;
      end
      if (k_val === 9'd0) zero = 1'b1;
      ref_clk = (rt0 >= 0 && (j == rt0 || j == rt0 + 1)) ||
                (rt1 >= 0 && (j == rt1 || j == rt1 + 1));
      dco_clk = (dt0 >= 0 && (j == dt0 || j == dt0 + 1)) ||
                (dt1 >= 0 && (j == dt1 || j == dt1 + 1));
      enable  = !(en_off >= 0 && j >= en_off && j < en_on);
      @(posedge clk);
      @(negedge clk);
    end
    if (np == 0) begin
      kv = k_val;
      lk = lock;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; ref_clk = 1'b0; dco_clk = 1'b0; enable = 1'b1;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    int np, at; logic [8:0] kv; logic lk; bit z;
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ref_clk = ~ref_clk;
      dco_clk = 1'($urandom);
      enable  = 1'($urandom);
      @(posedge clk); @(negedge clk);
      vectors++;
      if (k_val !== 9'd64 || k_valid !== 1'b0 || lock !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_hold[%0d]: k_val=%0d k_valid=%b lock=%b, want 64/0/0", i, k_val, k_valid, lock);
      end
    end
    ref_clk = 1'b0; dco_clk = 1'b0; enable = 1'b1;
    @(posedge clk); @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    run_pat(-1, -1, -1, -1, -1, -1, 10, np, at, kv, lk, z);
    vectors++;
    if (np !== 0) begin
      miscompares++; $display("FAIL reset_quiet_pulses: got %0d want 0", np);
    end
    vectors++;
    if (kv !== 9'd64 || lk !== 1'b0) begin
      miscompares++; $display("FAIL reset_quiet_state: k_val=%0d lock=%b want 64/0", kv, lk);
    end
  endtask

  task automatic test_same_cycle();
    int np, at; logic [8:0] kv; logic lk; bit z;
    do_reset();
    run_pat(3, -1, 3, -1, -1, -1, 14, np, at, kv, lk, z);
    model_update(0);
    vectors++;
    if (np !== 1 || at !== 7) begin
      miscompares++; $display("FAIL same_cycle_pulse: count=%0d at=%0d want 1 at 7", np, at);
    end
    vectors++;
    if (kv !== 9'(k_m) || kv !== 9'd64) begin
      miscompares++; $display("FAIL same_cycle_k: got %0d want %0d", kv, k_m);
    end
  endtask

  task automatic test_ref_lead();
    int np, at; logic [8:0] kv; logic lk; bit z;
    do_reset();
    run_pat(2, -1, 22, -1, -1, -1, 30, np, at, kv, lk, z);
    model_update(20);
    vectors++;
    if (np !== 1 || at !== 26) begin
      miscompares++; $display("FAIL ref_lead_pulse: count=%0d at=%0d want 1 at 26", np, at);
    end
    vectors++;
    if (kv !== 9'(k_m) || kv !== 9'd69) begin
      miscompares++; $display("FAIL ref_lead_k: got %0d want %0d", kv, k_m);
    end
  endtask

  task automatic test_ref_slip();
    int np, at; logic [8:0] kv; logic lk; bit z;
    do_reset();
    run_pat(2, 8, -1, -1, -1, -1, 18, np, at, kv, lk, z);
    model_update(511);
    vectors++;
    if (np !== 1 || at !== 12) begin
      miscompares++; $display("FAIL ref_slip_pulse: count=%0d at=%0d want 1 at 12", np, at);
    end
    vectors++;
    if (kv !== 9'(k_m) || kv !== 9'd206) begin
      miscompares++; $display("FAIL ref_slip_k: got %0d want %0d", kv, k_m);
    end
  endtask

  task automatic test_dco_slip_sat();
    int np, at; logic [8:0] kv; logic lk; bit z;
    do_reset();
    for (int i = 0; i < 36; i++) begin
      run_pat(-1, -1, 2, 6, -1, -1, 12, np, at, kv, lk, z);
      model_update(-511);
      vectors++;
      if (np !== 1 || at !== 10) begin
        miscompares++; $display("FAIL dco_slip_pulse[%0d]: count=%0d at=%0d want 1 at 10", i, np, at);
      end
      vectors++;
      if (kv !== 9'(k_m) || z !== 1'b0) begin
        miscompares++; $display("FAIL dco_slip_k[%0d]: got %0d (zero_seen=%b) want %0d", i, kv, z, k_m);
      end
    end
    // Pull back with reference slips. If the integrator had wrapped instead of
    // saturating, k would jump high here.
    for (int i = 0; i < 3; i++) begin
      run_pat(2, 8, -1, -1, -1, -1, 16, np, at, kv, lk, z);
      model_update(511);
      vectors++;
      if (kv !== 9'(k_m)) begin
        miscompares++; $display("FAIL sat_recover_k[%0d]: got %0d want %0d", i, kv, k_m);
      end
    end
  endtask

  task automatic test_enable();
    int np, at; logic [8:0] kv; logic lk; bit z;
    do_reset();
    run_pat(2, -1, 15, -1, 8, 30, 36, np, at, kv, lk, z);
    vectors++;
    if (np !== 0) begin
      miscompares++; $display("FAIL enable_abandon_pulses: got %0d want 0", np);
    end
    vectors++;
    if (kv !== 9'(k_m)) begin
      miscompares++; $display("FAIL enable_hold_k: got %0d want %0d", kv, k_m);
    end
    run_pat(2, -1, 9, -1, -1, -1, 16, np, at, kv, lk, z);
    model_update(7);
    vectors++;
    if (np !== 1 || at !== 13) begin
      miscompares++; $display("FAIL enable_fresh_pulse: count=%0d at=%0d want 1 at 13", np, at);
    end
    vectors++;
    if (kv !== 9'(k_m)) begin
      miscompares++; $display("FAIL enable_fresh_k: got %0d want %0d", kv, k_m);
    end
  endtask

  task automatic test_lock();
    int np, at, gap, err, close; logic [8:0] kv; logic lk; bit z, ref_lead;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      gap      = (i == 16) ? 5 : int'($urandom_range(0, 2));
      ref_lead = 1'($urandom);
      err      = ref_lead ? gap : -gap;
      close    = 2 + gap;
      if (ref_lead) run_pat(2, -1, close, -1, -1, -1, close + 6, np, at, kv, lk, z);
      else          run_pat(close, -1, 2, -1, -1, -1, close + 6, np, at, kv, lk, z);
      model_update(err);
      vectors++;
      if (np !== 1 || at !== close + 4 || kv !== 9'(k_m)) begin
        miscompares++;
        $display("FAIL lock_update[%0d]: count=%0d at=%0d k=%0d want 1 at %0d k=%0d", i, np, at, kv, close + 4, k_m);
      end
      vectors++;
      if (lk !== lock_m) begin
        miscompares++; $display("FAIL lock_state[%0d]: got %b want %b (err=%0d)", i, lk, lock_m, err);
      end
    end
  endtask

  task automatic test_back_to_back();
    int np, at, gap, err, close, kind; logic [8:0] kv; logic lk; bit z;
    for (int i = 0; i < 30; i++) begin
      kind = int'($urandom_range(0, 7));
      gap  = int'($urandom_range(0, 40));
      if (kind == 6) begin
        gap = int'($urandom_range(4, 30)); err = 511; close = 2 + gap;
        run_pat(2, close, -1, -1, -1, -1, close + 6, np, at, kv, lk, z);
      end else if (kind == 7) begin
        gap = int'($urandom_range(4, 30)); err = -511; close = 2 + gap;
        run_pat(-1, -1, 2, close, -1, -1, close + 6, np, at, kv, lk, z);
      end else if (kind[0]) begin
        err = gap; close = 2 + gap;
        run_pat(2, -1, close, -1, -1, -1, close + 6, np, at, kv, lk, z);
      end else begin
        err = -gap; close = 2 + gap;
        run_pat(close, -1, 2, -1, -1, -1, close + 6, np, at, kv, lk, z);
      end
      model_update(err);
      vectors++;
      if (np !== 1 || at !== close + 4) begin
        miscompares++; $display("FAIL b2b_pulse[%0d]: count=%0d at=%0d want 1 at %0d", i, np, at, close + 4);
      end
      vectors++;
      if (kv !== 9'(k_m) || lk !== lock_m || z !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b_value[%0d]: k=%0d lock=%b zero=%b want k=%0d lock=%b (err=%0d)", i, kv, lk, z, k_m, lock_m, err);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; ref_clk = 1'b0; dco_clk = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_same_cycle();
    test_ref_lead();
    test_ref_slip();
    test_dco_slip_sat();
    test_enable();
    test_lock();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
